div_unit_mc: RTL and testbench
==============================

# div_unit_mc

Multi-cycle iterative integer divider for the pipelined datapath's execute stage, implementing RISC-V M-extension DIV/DIVU/REM/REMU at parametrised width. It replaces a single-cycle combinational result path with a start/busy/done handshake. A stall output drives the hazard unit so that StallF/StallD and FlushE hold the pipeline until the quotient or remainder is ready. The destination register tag travels with the operation for writeback and forwarding.

## Interface
Parameters:
- WIDTH, 32: operand and result width in bits; must be ≥ 8 and even.
- TAGW, 5: destination-register tag width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a divide; sampled only when accepted (see Operation).
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  in  WIDTH  dividend (SrcAE after forwarding).
- b  in  WIDTH  divisor (SrcBE after forwarding).
- rd_in  in  TAGW  destination register of the request.
- flush  in  1  abort the operation in flight.
- busy  out  1  high while an operation is in flight (state ≠ IDLE, DONE).
- stall_o  out  1  busy | (start & accept); combinational; drives the hazard unit.
- done  out  1  one-cycle pulse; result and rd_out are valid.
- result  out  WIDTH  quotient or remainder; holds until next acceptance.
- rd_out  out  TAGW  tag of the completed operation.

## Operation
- States: IDLE, PREP, ITER, DONE.
- Acceptance: start is accepted in IDLE or DONE. Start is ignored in PREP or ITER. An ignored start does not assert stall_o beyond busy.
- On acceptance: latch op, rd_in, and operand signs. Go to PREP.
- PREP, 1 cycle:
  - Load |a| and |b| into the work registers. Signs count only for DIV/REM.
  - Clear the partial remainder.
  - Load the iteration counter with WIDTH-1.
  - Go to ITER.
- ITER, WIDTH cycles:
  - One restoring step per cycle: shift {rem, quo} left by 1, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
  - When the counter reaches 0, register the final result and go to DONE.
- Sign correction, applied when registering the result:
  - Negate the quotient if the operand signs differ (signed ops).
  - The remainder takes the dividend's sign.
- Special cases override the computed value:
  - b == 0: quotient = all ones; remainder = a.
  - Signed overflow (a = min, b = -1): quotient = min; remainder = 0.
- DONE, 1 cycle: done = 1. If start is present, go to PREP; otherwise go to IDLE.
- flush in any state: go to IDLE on the next edge. No done is produced. result and rd_out hold their previous values.
- flush and start in the same cycle: flush wins; the start is dropped.
- reset: state = IDLE. busy, done, and stall_o = 0. result = 0. rd_out = 0. Work registers and counter = 0.

## Timing
- Start accepted at edge N: PREP in cycle N+1, ITER in cycles N+2 .. N+WIDTH+1, DONE (done = 1) in cycle N+WIDTH+2.
- Latency is WIDTH+2 cycles, i.e. 34 for WIDTH = 32.
- Throughput is one operation per WIDTH+2 cycles, with back-to-back issue from DONE.
- stall_o rises in the same cycle as an accepted start. It falls in the DONE cycle, unless a new start is accepted then.
- result and rd_out are registered and stable from DONE until the next result is registered.

## Configuration
- DIV_FASTPATH_EN defined:
  - b == 0 or signed overflow, detected at acceptance, goes PREP → DONE.
  - The special-case result is registered in PREP.
  - Latency is 2 cycles.
- DIV_FASTPATH_EN undefined:
  - All operations take WIDTH+2 cycles.
  - Special-case values are still applied at the end of ITER, so results are identical.

## Structure
- div_pkg:
  - div_op_e enum (DIV, DIVU, REM, REMU).
  - div_state_e enum (IDLE, PREP, ITER, DONE).
  - Localparam for the counter width, $clog2(WIDTH).
- Sub-module div_step: combinational single restoring step. Inputs are {rem, quo} and the divisor; outputs are the next {rem, quo}. Parametrised by WIDTH.
- The top level holds the FSM, counter, sign and special-case logic, and the output registers.

## Test plan
All scenarios use WIDTH = 32.
- DIV 100 / 7 → result 14, done exactly 34 cycles after the start edge; REM 100 / 7 → 2; rd_out equals rd_in.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5. Latency is 2 with DIV_FASTPATH_EN and 34 without.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Flush 10 cycles after start → busy = 0 on the next cycle, no done pulse, result unchanged. A start asserted mid-ITER is ignored and produces no second done.
- Start held during DONE → the second operation is accepted, stall_o stays high, and the second done arrives 34 cycles later. Reset asserted mid-ITER → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the multi-cycle divider: operation codes, FSM states
// and the default iteration-counter width.
package div_pkg;

  // Operation encoding as presented on the op port.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    ITER = 2'b10,
    DONE = 2'b11
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;
  localparam int DIV_CNTW_DEFAULT  = $clog2(DIV_WIDTH_DEFAULT);

  // Signed variants (DIV, REM) have op[0] clear.
  function automatic logic opIsSigned(div_op_e opCode);
    return ~opCode[0];
  endfunction

  // Remainder variants (REM, REMU) have op[1] set.
  function automatic logic opIsRem(div_op_e opCode);
    return opCode[1];
  endfunction

endpackage

// File: rtl/div_unit_mc_step.sv
// One combinational restoring-division step: shift {rem, quo} left by one,
// trial-subtract the divisor and keep the difference if it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Extra top bit of the trial difference acts as the borrow/sign flag.
  always_comb begin
    shifted = {remIn, quoIn[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      remOut = trial[WIDTH-1:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b1};
    end else begin
      remOut = shifted[WIDTH-1:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit_mc.sv
// Multi-cycle iterative divider (DIV/DIVU/REM/REMU) with start/busy/done
// handshake and a stall output for the hazard unit.
// Optional feature macro: DIV_FASTPATH_EN -- when defined, divide-by-zero
// and signed overflow finish straight from PREP with a 2-cycle latency.
module div_unit_mc
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAGW-1:0]  rd_in,
  input  logic             flush,
  output logic             busy,
  output logic             stall_o,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [TAGW-1:0]  rd_out
);

  localparam int CNTW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNTW-1:0]  CNT_START = CNTW'(WIDTH - 1);

  div_state_e state, stateNext;

  div_op_e          opReg;
  logic [TAGW-1:0]  rdReg;
  logic [WIDTH-1:0] aReg, bReg;
  logic [WIDTH-1:0] remReg, quoReg, divisorReg;
  logic [CNTW-1:0]  cntReg;
  logic [WIDTH-1:0] resultReg;
  logic [TAGW-1:0]  rdOutReg;

  logic             accept;
  logic             opSigned;
  logic             aNeg, bNeg;
  logic [WIDTH-1:0] absA, absB;
  logic             divByZero, signedOvf, isSpecial;
  logic [WIDTH-1:0] stepRem, stepQuo;
  logic [WIDTH-1:0] quoSigned, remSigned;
  logic [WIDTH-1:0] resultNext;

  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn  (remReg),
    .quoIn  (quoReg),
    .divisor(divisorReg),
    .remOut (stepRem),
    .quoOut (stepQuo)
  );

  // A start is only taken when idle or finishing, and never alongside a flush.
  always_comb begin
    accept = start & ~flush & ((state == IDLE) | (state == DONE));
  end

  // Operand signs, magnitudes and special-case detection from latched operands.
  always_comb begin
    opSigned  = opIsSigned(opReg);
    aNeg      = opSigned & aReg[WIDTH-1];
    bNeg      = opSigned & bReg[WIDTH-1];
    absA      = aNeg ? -aReg : aReg;
    absB      = bNeg ? -bReg : bReg;
    divByZero = (bReg == '0);
    signedOvf = opSigned & (aReg == MIN_VAL) & (bReg == '1);
    isSpecial = divByZero | signedOvf;
  end

  // Final value: sign-correct the last step, then let special cases override.
  always_comb begin
    quoSigned  = (aNeg ^ bNeg) ? -stepQuo : stepQuo;
    remSigned  = aNeg ? -stepRem : stepRem;
    resultNext = opIsRem(opReg) ? remSigned : quoSigned;
    if (divByZero) begin
      resultNext = opIsRem(opReg) ? aReg : '1;
    end else if (signedOvf) begin
      resultNext = opIsRem(opReg) ? '0 : MIN_VAL;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) stateNext = PREP;
      end
      PREP: begin
`ifdef DIV_FASTPATH_EN
        stateNext = isSpecial ? DONE : ITER;
`else
        stateNext = ITER;
`endif
      end
      ITER: begin
        if (cntReg == '0) stateNext = DONE;
      end
      DONE: begin
        stateNext = accept ? PREP : IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (flush) stateNext = IDLE;
  end

  // Request latching, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      opReg      <= DIV;
      rdReg      <= '0;
      aReg       <= '0;
      bReg       <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      cntReg     <= '0;
      resultReg  <= '0;
      rdOutReg   <= '0;
    end else begin
      if (accept) begin
        opReg <= div_op_e'(op);
        rdReg <= rd_in;
        aReg  <= a;
        bReg  <= b;
      end
      case (state)
        PREP: begin
          if (!flush) begin
            quoReg     <= absA;
            divisorReg <= absB;
            remReg     <= '0;
            cntReg     <= CNT_START;
`ifdef DIV_FASTPATH_EN
            if (isSpecial) begin
              resultReg <= resultNext;
              rdOutReg  <= rdReg;
            end
`endif
          end
        end
        ITER: begin
          if (!flush) begin
            remReg <= stepRem;
            quoReg <= stepQuo;
            cntReg <= cntReg - 1'b1;
            if (cntReg == '0) begin
              resultReg <= resultNext;
              rdOutReg  <= rdReg;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs.
  always_comb begin
    busy    = (state == PREP) | (state == ITER);
    done    = (state == DONE);
    stall_o = busy | accept;
    result  = resultReg;
    rd_out  = rdOutReg;
  end

endmodule

// File: tb/tb_div_unit_mc.sv
// Directed/random bench for div_unit_mc (WIDTH = 32) using a scoreboard queue
// of expected results, tags and latencies.
module tb_div_unit_mc;

  localparam int WIDTH = 32;
  localparam int TAGW  = 5;
  localparam logic [31:0] MINV = 32'h8000_0000;
`ifdef DIV_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b, result;
  logic [4:0]  rdIn, rdOut;
  logic        busy, stallO, done;

  exp_t        sbQueue[$];
  int          checkCount = 0;
  int          passCount  = 0;
  int          curIdx     = 0;
  logic [31:0] lastResult = '0;

  div_unit_mc #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rdIn),
    .flush  (flush),
    .busy   (busy),
    .stall_o(stallO),
    .done   (done),
    .result (result),
    .rd_out (rdOut)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference results straight from the ISA definition.
  function automatic logic [31:0] refDiv(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == MINV && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : MINV;
    case (o)
      2'b00:   return sx / sy;
      2'b01:   return x / y;
      2'b10:   return sx % sy;
      default: return x % y;
    endcase
  endfunction

  function automatic int refLat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic special;
    special = (y == 32'd0) || (!o[0] && x == MINV && y == 32'hFFFF_FFFF);
    return (FASTPATH && special) ? 2 : WIDTH + 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else $error("[TB] FAIL %s: observed 0x%08h, required 0x%08h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    curIdx++;
  endtask

  // Drive one request, push its expectation, return at the first cycle after acceptance.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [4:0] r, input string tag);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    rdIn  = r;
    e.res = refDiv(o, x, y);
    e.rd  = r;
    e.lat = refLat(o, x, y);
    sbQueue.push_back(e);
    #1 checkOutput({tag, "_stallOnStart"}, {31'd0, stallO}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    curIdx = 1;
  endtask

  // Compare the current DONE cycle against the head of the scoreboard.
  task automatic popAndCompare(input string tag);
    exp_t e;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 32'd1, 32'd0);
    end else begin
      e = sbQueue.pop_front();
      checkOutput({tag, "_latency"}, curIdx, e.lat);
      checkOutput({tag, "_result"}, result, e.res);
      checkOutput({tag, "_rd"}, {27'd0, rdOut}, {27'd0, e.rd});
      checkOutput({tag, "_busyInDone"}, {31'd0, busy}, 32'd0);
      lastResult = e.res;
    end
  endtask

  task automatic waitDone(input string tag);
    int guard;
    guard = 0;
    while (!done && guard < 200) begin
      tick();
      guard++;
    end
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    if (done) popAndCompare(tag);
  endtask

  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) n++;
    end
  endtask

  initial begin
    int nDone;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    rdIn  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_stall", {31'd0, stallO}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_rd", {27'd0, rdOut}, 32'd0);
    reset = 1'b0;

    $display("[TB] directed arithmetic");
    applyStimulus(2'b00, 32'd100, 32'd7, 5'd5, "div100_7");
    waitDone("div100_7");
    applyStimulus(2'b10, 32'd100, 32'd7, 5'd9, "rem100_7");
    waitDone("rem100_7");
    applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, "divNeg7_2");
    waitDone("divNeg7_2");
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, "remNeg7_2");
    waitDone("remNeg7_2");
    applyStimulus(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd3, "divuBig_2");
    waitDone("divuBig_2");

    $display("[TB] special cases");
    applyStimulus(2'b01, 32'd5, 32'd0, 5'd10, "divu5_0");
    waitDone("divu5_0");
    applyStimulus(2'b11, 32'd5, 32'd0, 5'd11, "remu5_0");
    waitDone("remu5_0");
    applyStimulus(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd12, "remNeg5_0");
    waitDone("remNeg5_0");
    applyStimulus(2'b00, MINV, 32'hFFFF_FFFF, 5'd13, "divOvf");
    waitDone("divOvf");
    applyStimulus(2'b10, MINV, 32'hFFFF_FFFF, 5'd14, "remOvf");
    waitDone("remOvf");

    $display("[TB] random operations");
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (ro[0] == 1'b0 && (i % 3 == 0)) rb = -rb;
      applyStimulus(ro, ra, rb, 5'(i + 16), "rand");
      waitDone("rand");
    end

    $display("[TB] flush mid-operation");
    applyStimulus(2'b00, 32'd1000, 32'd3, 5'd7, "flush");
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(sbQueue.pop_front());
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_stall", {31'd0, stallO}, 32'd0);
    checkOutput("flush_resultHeld", result, lastResult);
    countDones(40, nDone);
    checkOutput("flush_noDone", nDone, 32'd0);
    checkOutput("flush_resultStill", result, lastResult);

    $display("[TB] start ignored while iterating");
    applyStimulus(2'b00, 32'd20, 32'd4, 5'd3, "ignore");
    repeat (9) tick();
    start = 1'b1;
    op    = 2'b10;
    a     = 32'd9;
    b     = 32'd2;
    rdIn  = 5'd30;
    #1 checkOutput("ignore_stallBusy", {31'd0, stallO}, 32'd1);
    tick();
    start = 1'b0;
    waitDone("ignore");
    countDones(40, nDone);
    checkOutput("ignore_noSecondDone", nDone, 32'd0);

    $display("[TB] back-to-back issue from DONE");
    applyStimulus(2'b00, 32'd100, 32'd7, 5'd1, "b2b1");
    while (curIdx < WIDTH + 1) tick();
    begin
      exp_t e2;
      start  = 1'b1;
      op     = 2'b10;
      a      = 32'd100;
      b      = 32'd7;
      rdIn   = 5'd2;
      e2.res = refDiv(2'b10, 32'd100, 32'd7);
      e2.rd  = 5'd2;
      e2.lat = WIDTH + 2;
      sbQueue.push_back(e2);
    end
    tick();
    checkOutput("b2b1_done", {31'd0, done}, 32'd1);
    checkOutput("b2b_stallInDone", {31'd0, stallO}, 32'd1);
    popAndCompare("b2b1");
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    curIdx = 1;
    checkOutput("b2b_stallPrep", {31'd0, stallO}, 32'd1);
    waitDone("b2b2");

    $display("[TB] reset mid-iteration");
    applyStimulus(2'b01, 32'd12345, 32'd11, 5'd4, "rst");
    repeat (9) tick();
    reset = 1'b1;
    tick();
    sbQueue.delete();
    checkOutput("rstIter_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstIter_done", {31'd0, done}, 32'd0);
    checkOutput("rstIter_stall", {31'd0, stallO}, 32'd0);
    checkOutput("rstIter_result", result, 32'd0);
    checkOutput("rstIter_rd", {27'd0, rdOut}, 32'd0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
